// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: control, redirect and instruction inputs plus PC/status outputs.
// PC_CYCLE_COUNT_EN adds o_cycle_count to both modports.
interface pc_fetch_unit_if #(
    parameter int len_addr = 32,
    parameter int len_data = 32
);
    logic                i_start;
    logic                i_step_mode;
    logic                i_step;
    logic                i_stall;
    logic                i_branch_taken;
    logic [len_addr-1:0] i_branch_addr;
    logic                i_jump;
    logic [len_addr-1:0] i_jump_addr;
    logic [len_data-1:0] i_instr;
    logic [len_addr-1:0] o_pc;
    logic [len_addr-1:0] o_pc_next;
    logic                o_fetch_en;
    logic                o_running;
    logic                o_halted;
`ifdef PC_CYCLE_COUNT_EN
    logic [len_addr-1:0] o_cycle_count;

    modport master (
        output i_start, i_step_mode, i_step, i_stall,
        output i_branch_taken, i_branch_addr, i_jump, i_jump_addr, i_instr,
        input  o_pc, o_pc_next, o_fetch_en, o_running, o_halted,
        input  o_cycle_count
    );
    modport slave (
        input  i_start, i_step_mode, i_step, i_stall,
        input  i_branch_taken, i_branch_addr, i_jump, i_jump_addr, i_instr,
        output o_pc, o_pc_next, o_fetch_en, o_running, o_halted,
        output o_cycle_count
    );
`else
    modport master (
        output i_start, i_step_mode, i_step, i_stall,
        output i_branch_taken, i_branch_addr, i_jump, i_jump_addr, i_instr,
        input  o_pc, o_pc_next, o_fetch_en, o_running, o_halted
    );
    modport slave (
        input  i_start, i_step_mode, i_step, i_stall,
        input  i_branch_taken, i_branch_addr, i_jump, i_jump_addr, i_instr,
        output o_pc, o_pc_next, o_fetch_en, o_running, o_halted
    );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: run/step control, redirects, stall, HALT detect.
// Define PC_CYCLE_COUNT_EN to add the issued-instruction counter o_cycle_count.
module pc_fetch_unit #(
    parameter int                  len_addr   = 32,
    parameter int                  len_data   = 32,
    parameter logic [len_addr-1:0] RESET_PC   = '0,
    parameter logic [len_data-1:0] HALT_INSTR = '1
) (
    input logic              clk,
    input logic              reset,
    pc_fetch_unit_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;

    localparam logic [len_addr-1:0] PC_ONE = {{(len_addr-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_next;
    logic [len_addr-1:0] r_pc;
    logic [len_addr-1:0] w_pc_inc;
    logic [len_addr-1:0] w_pc_load;
    logic                w_adv;
    logic                w_issue;
    logic                w_halt;

    assign w_pc_inc = r_pc + PC_ONE;

    always_comb begin
        w_adv        = 1'b0;
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start)
                    w_state_next = bus.i_step_mode ? S_STEP : S_RUN;
            end
            S_RUN:   w_adv = 1'b1;
            S_STEP:  w_adv = bus.i_step;
            default: w_adv = 1'b0;
        endcase

        w_issue = w_adv & ~bus.i_stall;
        // A redirect in the same cycle means HALT is on the wrong path.
        w_halt  = w_issue & (bus.i_instr == HALT_INSTR)
                & ~bus.i_jump & ~bus.i_branch_taken;
        if (w_halt)
            w_state_next = S_HALTED;

        w_pc_load = r_pc;
        if (w_adv) begin
            if (bus.i_jump)
                w_pc_load = bus.i_jump_addr;
            else if (bus.i_branch_taken)
                w_pc_load = bus.i_branch_addr;
            else if (!bus.i_stall && !w_halt)
                w_pc_load = w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_load;
        end
    end

    assign bus.o_pc       = r_pc;
    assign bus.o_pc_next  = w_pc_inc;
    assign bus.o_fetch_en = w_issue & ~w_halt;
    assign bus.o_running  = (r_state == S_RUN) || (r_state == S_STEP);
    assign bus.o_halted   = (r_state == S_HALTED);

`ifdef PC_CYCLE_COUNT_EN
    logic [len_addr-1:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_cycle_count <= '0;
        else if (w_issue && !w_halt)
            r_cycle_count <= r_cycle_count + PC_ONE;
    end

    assign bus.o_cycle_count = r_cycle_count;
`endif
endmodule
